// File: rtl/baud_pkg.sv
// Shared constants and types for the programmable baud tick generator.
package baud_pkg;

  localparam int DIV_MIN      = 2;
  localparam int DIV_RST_DEF  = 163;
  localparam int FRAC_RST_DEF = 12;
  localparam int OVS_DEF      = 16;
  localparam int CLK_HZ       = 50_000_000;

  // Rate presets at 50 MHz with 16x oversampling: integer part and 1/16 fraction.
  localparam int DIV_9600    = 325;
  localparam int FRAC_9600   = 8;
  localparam int DIV_19200   = 162;
  localparam int FRAC_19200  = 12;
  localparam int DIV_115200  = 27;
  localparam int FRAC_115200 = 2;

  typedef enum logic {
    CFG_IDLE = 1'b0,
    CFG_PEND = 1'b1
  } cfg_state_t;

endpackage

// File: rtl/baud_os_counter.sv
// Modulo-OVS oversample counter; o_tc flags the last oversample of a bit.
module baud_os_counter #(
  parameter int OVS = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_tc
);

  localparam int            W    = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [W-1:0]  LAST = W'(OVS - 1);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + W'(1);
    end
  end

  assign o_tc = (r_cnt == LAST);

endmodule

// File: rtl/baud_gen_prog.sv
// Runtime-programmable baud tick generator with valid/ready divisor reload.
// Define BAUD_GEN_FRAC_EN to enable the fractional-divisor accumulator.
module baud_gen_prog
  import baud_pkg::*;
#(
  parameter int DIV_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OVS      = OVS_DEF,
  parameter int DIV_RST  = DIV_RST_DEF,
  parameter int FRAC_RST = FRAC_RST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              cfg_err,
  output logic              s_tick,
  output logic              b_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div_cur;
  logic [DIV_W-1:0] r_div_pnd;
  logic [DIV_W-1:0] w_pend;
  logic             r_cfg_err;
  cfg_state_t       r_state;
  cfg_state_t       w_state_nxt;
  logic             w_ext;
  logic             w_xfer;
  logic             w_bad;
  logic             w_capture;
  logic             w_activate;
  logic             w_clr;
  logic             w_os_tc;

  assign w_clr      = en & sync;
  assign w_xfer     = cfg_valid & cfg_ready;
  assign w_bad      = (div_int < DIV_W'(DIV_MIN));
  assign w_capture  = w_xfer & ~w_bad;
  // A reload only lands on a period boundary, or at once when the phase is frozen or restarted.
  assign w_activate = (r_state == CFG_PEND) & (s_tick | ~en | sync);
  assign w_pend     = r_div_cur - DIV_W'(1) + DIV_W'(w_ext);
  assign s_tick     = en & ~sync & (r_cnt == w_pend);
  assign b_tick     = s_tick & w_os_tc;
  assign cfg_err    = r_cfg_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_div_cur <= DIV_W'(DIV_RST);
      r_div_pnd <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_xfer & w_bad;
      if (w_clr || s_tick) begin
        r_cnt <= '0;
      end else if (en) begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
      if (w_capture) begin
        r_div_pnd <= div_int;
      end
      if (w_activate) begin
        r_div_cur <= r_div_pnd;
      end
    end
  end

`ifdef BAUD_GEN_FRAC_EN
  logic [FRAC_W-1:0] r_acc;
  logic [FRAC_W-1:0] r_frac_cur;
  logic [FRAC_W-1:0] r_frac_pnd;
  logic              r_ext;
  logic [FRAC_W:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, r_frac_cur};
  assign w_ext = r_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc      <= '0;
      r_ext      <= 1'b0;
      r_frac_cur <= FRAC_W'(FRAC_RST);
      r_frac_pnd <= '0;
    end else begin
      if (w_capture) begin
        r_frac_pnd <= div_frac;
      end
      if (w_activate) begin
        r_frac_cur <= r_frac_pnd;
      end
      if (w_activate || w_clr) begin
        {r_ext, r_acc} <= '0;
      end else if (s_tick) begin
        {r_ext, r_acc} <= w_sum;
      end
    end
  end
`else
  logic w_unused_frac;
  assign w_unused_frac = ^{div_frac, FRAC_W'(FRAC_RST)};
  assign w_ext         = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= CFG_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: assigning a default before the case keeps this block free of inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CFG_IDLE: if (w_capture)  w_state_nxt = CFG_PEND;
      CFG_PEND: if (w_activate) w_state_nxt = CFG_IDLE;
      default:                  w_state_nxt = CFG_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (r_state == CFG_IDLE);
  end

  baud_os_counter #(
    .OVS (OVS)
  ) u_os_counter (
    .clk   (clk),
    .reset (reset),
    .i_inc (s_tick),
    .i_clr (w_clr),
    .o_tc  (w_os_tc)
  );

endmodule

// File: tb/tb_baud_gen_prog.sv
// Self-checking bench for baud_gen_prog: directed scenarios plus random traffic
// checked every cycle against a period-level reference model.
module tb_baud_gen_prog;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OVS    = 16;
  localparam int FMOD   = 2 ** FRAC_W;
`ifdef BAUD_GEN_FRAC_EN
  localparam int FRAC_ON = 1;
`else
  localparam int FRAC_ON = 0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic              sync;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              cfg_err;
  logic              s_tick;
  logic              b_tick;

  int n_tests = 0;
  int n_fail  = 0;

  baud_gen_prog dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .div_int   (div_int),
    .div_frac  (div_frac),
    .cfg_err   (cfg_err),
    .s_tick    (s_tick),
    .b_tick    (b_tick)
  );

  always #5 clk = ~clk;

  // Reference model: position inside the current period, the length of that period,
  // ticks since the last alignment, and the active/pending divisors.
  int m_phase, m_len, m_ticks, m_div, m_frac, m_acc, m_pdiv, m_pfrac;
  bit m_pending, m_err;
  int cyc, first_s, first_b, last_s, last_b, n_s, n_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ticks = 0; m_acc = 0;
    m_div = 163; m_frac = 12; m_len = 163;
    m_pending = 1'b0; m_err = 1'b0; m_pdiv = 0; m_pfrac = 0;
    cyc = 0; first_s = -1; first_b = -1; last_s = -1; last_b = -1;
  endtask

  // Sum of the first OVS periods after an alignment with divisor d and fraction f.
  function automatic int bit_len(input int d, input int f);
    int acc = 0;
    int carry = 0;
    int t = 0;
    for (int k = 0; k < OVS; k++) begin
      t += d + carry;
      carry = FRAC_ON * ((acc + f) / FMOD);
      acc = (acc + f) % FMOD;
    end
    return t;
  endfunction

  // One clock cycle: compare outputs mid-cycle, then advance the model at the edge.
  task automatic step(input string tag);
    bit es, eb, act, was_p;
    int sum;
    @(negedge clk);
    es = en && !sync && (m_phase == m_len - 1);
    eb = es && ((m_ticks % OVS) == OVS - 1);
    check(tag, 32'({s_tick, b_tick, cfg_ready, cfg_err}),
          32'({es, eb, !m_pending, m_err}));
    if (s_tick === 1'b1) begin
      n_s++; last_s = cyc;
      if (first_s < 0) first_s = cyc;
    end
    if (b_tick === 1'b1) begin
      n_b++; last_b = cyc;
      if (first_b < 0) first_b = cyc;
    end
    @(posedge clk);
    was_p = m_pending;
    act   = was_p && (es || !en || sync);
    m_err = cfg_valid && !was_p && (div_int < 2);
    if (en && sync) begin
      m_phase = 0; m_ticks = 0; m_acc = 0; m_len = m_div;
    end else if (es) begin
      m_phase = 0; m_ticks++;
      sum = m_acc + m_frac;
      m_acc = sum % FMOD;
      m_len = m_div + FRAC_ON * (sum / FMOD);
    end else if (en) begin
      m_phase++;
    end
    if (act) begin
      m_div = m_pdiv; m_frac = m_pfrac; m_acc = 0; m_len = m_div; m_pending = 1'b0;
    end
    if (!was_p && cfg_valid && div_int >= 2) begin
      m_pending = 1'b1; m_pdiv = int'(div_int); m_pfrac = int'(div_frac);
    end
    cyc++;
    #1;
  endtask

  task automatic wait_tick(input string tag, input int bound);
    int n0 = n_s;
    int k = 0;
    while (n_s == n0 && k < bound) begin
      step(tag);
      k++;
    end
    check({tag, "_seen"}, 32'(n_s != n0), 32'd1);
  endtask

  initial begin
    int c0, n0, p, k;
    reset = 1'b1; en = 1'b0; sync = 1'b0; cfg_valid = 1'b0;
    div_int = '0; div_frac = '0;
    n_s = 0; n_b = 0;
    model_reset();
    #12;
    en = 1'b1;
    #1;
    check("reset_state", 32'({s_tick, b_tick, cfg_ready, cfg_err}), 32'd2);

    // Reset defaults with en held high.
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    repeat (2700) step("defaults");
    check("first_s_tick", 32'(first_s), 32'd162);
    check("first_b_tick", 32'(first_b), 32'(bit_len(163, 12) - 1));

    // Phase restart at os_cnt=7, cnt=50.
    k = 0;
    while (!((m_ticks % OVS) == 7 && m_phase == 50) && k < 3000) begin
      step("seek_sync"); k++;
    end
    check("sync_point_found", 32'((m_ticks % OVS) == 7 && m_phase == 50), 32'd1);
    c0 = cyc;
    sync = 1'b1; step("sync_cycle"); sync = 1'b0;
    wait_tick("sync_s", 400);
    check("sync_s_gap", 32'(last_s - c0), 32'd163);
    n0 = n_b; k = 0;
    while (n_b == n0 && k < 3000) begin
      step("sync_b"); k++;
    end
    check("sync_b_gap", 32'(last_b - c0), 32'(bit_len(163, 12)));

    // Load D=10, then reload D=5 while cnt=3.
    div_int = 16'd10; div_frac = 4'd0; cfg_valid = 1'b1;
    step("cfg10_offer"); cfg_valid = 1'b0;
    check("cfg10_ready_low", 32'(cfg_ready), 32'd0);
    k = 0;
    while (!(m_phase == 3 && m_len == 10 && !m_pending) && k < 400) begin
      step("seek_cnt3"); k++;
    end
    check("cnt3_found", 32'(m_phase == 3 && m_len == 10), 32'd1);
    c0 = cyc;
    div_int = 16'd5; cfg_valid = 1'b1;
    step("cfg5_offer"); cfg_valid = 1'b0;
    check("cfg5_ready_low", 32'(cfg_ready), 32'd0);
    wait_tick("reload_tick", 20);
    check("reload_no_runt", 32'(last_s - c0), 32'd6);
    check("reload_ready_back", 32'(cfg_ready), 32'd1);
    p = last_s;
    wait_tick("period5", 20);
    check("period5_gap", 32'(last_s - p), 32'd5);

    // Illegal divisor.
    div_int = 16'd1; cfg_valid = 1'b1;
    step("bad_offer"); cfg_valid = 1'b0;
    check("err_pulse", 32'({cfg_err, cfg_ready}), 32'd3);
    step("after_bad");
    check("err_single", 32'(cfg_err), 32'd0);
    wait_tick("after_bad_a", 20);
    p = last_s;
    wait_tick("after_bad_b", 20);
    check("bad_period_kept", 32'(last_s - p), 32'd5);

    // Fractional divisor 10 + 8/16, aligned by sync.
    div_int = 16'd10; div_frac = 4'd8; cfg_valid = 1'b1;
    step("frac_offer"); cfg_valid = 1'b0;
    k = 0;
    while (m_pending && k < 20) begin
      step("frac_wait"); k++;
    end
    sync = 1'b1; step("frac_sync"); sync = 1'b0;
    n0 = n_s;
    repeat (168) step("frac_run");
    check("frac_16_in_168", 32'(n_s - n0), 32'd16);

    // Enable dropped for 20 cycles mid-period.
    k = 0;
    while (m_phase != 4 && k < 20) begin
      step("seek_en"); k++;
    end
    en = 1'b0; n0 = n_s;
    repeat (20) step("en_low");
    check("en_low_no_ticks", 32'(n_s - n0), 32'd0);
    en = 1'b1; c0 = cyc; p = m_len;
    wait_tick("en_resume", 20);
    check("en_resume_gap", 32'(last_s - c0), 32'(p - 5));

    // Asynchronous reset in a tick cycle with a divisor pending.
    k = 0;
    while (m_phase != m_len - 3 && k < 20) begin
      step("seek_rst"); k++;
    end
    div_int = 16'd7; div_frac = 4'd0; cfg_valid = 1'b1;
    step("rst_offer"); cfg_valid = 1'b0;
    step("rst_pre");
    check("pre_reset_tick", 32'({s_tick, cfg_ready}), 32'd2);
    reset = 1'b1;
    #1;
    check("reset_async", 32'({s_tick, b_tick, cfg_ready, cfg_err}), 32'd2);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    repeat (170) step("after_reset");
    check("reset_div_restored", 32'(first_s), 32'd162);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      en        = m_pending ? 1'b1 : ($urandom_range(0, 15) != 0);
      sync      = ($urandom_range(0, 59) == 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      div_int   = 16'($urandom_range(0, 24));
      div_frac  = 4'($urandom_range(0, 15));
      step("random");
    end
    en = 1'b1; sync = 1'b0; cfg_valid = 1'b0;
    check("random_saw_b_tick", 32'(n_b > 3), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
